diff_line_tx: RTL and testbench

DIFF_LINE_TX -- requirements
Module: diff_line_tx

---
 rtl/diff_line_pkg.sv | 26 ++
 rtl/diff_line_bit_timer.sv | 30 +++
 rtl/diff_line_tx.sv | 127 ++++++++++++
 tb/tb_diff_line_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_line_pkg.sv
// Shared types and constants for the differential line transmitter.
// Optional even-parity bit is compiled in with macro DIFF_LINE_TX_PARITY_EN.
package diff_line_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int IDX_W  = 3;

    // Line symbols are packed as {tx_p, tx_n}.
    typedef logic [1:0] sym_t;

    localparam sym_t SYM_ONE  = 2'b10;
    localparam sym_t SYM_ZERO = 2'b01;
    localparam sym_t SYM_CM   = 2'b00;

`ifdef DIFF_LINE_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    function automatic sym_t bit_sym(input logic b);
        return b ? SYM_ONE : SYM_ZERO;
    endfunction

endpackage

// File: rtl/diff_line_bit_timer.sv
// Bit-period down-counter: reload starts a new period, tick marks its last cycle.
module diff_line_bit_timer
    import diff_line_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Reloading with CLKS_PER_BIT-1 makes tick land on the final cycle of the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (reload) begin
            count <= RELOAD_VAL;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/diff_line_tx.sv
// Differential line transmitter: START(1), 8 data bits LSB first, optional parity, STOP(CM).
// Parity bit is compiled in with macro DIFF_LINE_TX_PARITY_EN.
module diff_line_tx
    import diff_line_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx_p,
    output logic              tx_n,
    output logic              busy
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [IDX_W-1:0]  bit_idx;
    logic              armed;
    logic              tick;
    logic              accept;
    logic              reload;
    logic              last_bit;
    sym_t              line;
`ifdef DIFF_LINE_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign accept   = valid && ready;
    assign reload   = accept || (tick && (state != IDLE));
    assign last_bit = (bit_idx == IDX_W'(DATA_W - 1));

    diff_line_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .reload(reload),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept) state_next = START;
            START:  if (tick) state_next = DATA;
`ifdef DIFF_LINE_TX_PARITY_EN
            DATA:   if (tick && last_bit) state_next = PARITY;
            PARITY: if (tick) state_next = STOP;
`else
            DATA:   if (tick && last_bit) state_next = STOP;
`endif
            STOP:   if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // armed keeps ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            bit_idx    <= '0;
            armed      <= 1'b0;
`ifdef DIFF_LINE_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            armed <= 1'b1;
            if (accept) begin
                shift_reg  <= data_in;
                bit_idx    <= '0;
`ifdef DIFF_LINE_TX_PARITY_EN
                parity_bit <= ^data_in;
`endif
            end else if ((state == DATA) && tick) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= bit_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        line  = SYM_CM;
        ready = 1'b0;
        busy  = 1'b0;
        case (state)
            IDLE: begin
                ready = armed;
            end
            START: begin
                busy = 1'b1;
                line = SYM_ONE;
            end
            DATA: begin
                busy = 1'b1;
                line = bit_sym(shift_reg[0]);
            end
`ifdef DIFF_LINE_TX_PARITY_EN
            PARITY: begin
                busy = 1'b1;
                line = bit_sym(parity_bit);
            end
`endif
            STOP: begin
                busy = 1'b1;
            end
            default: begin
                line = SYM_CM;
            end
        endcase
    end

    assign tx_p = line[1];
    assign tx_n = line[0];

endmodule

// File: tb/tb_diff_line_tx.sv
// Self-checking bench for diff_line_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
// Builds with or without DIFF_LINE_TX_PARITY_EN; expected frames come from a symbol-list model.
module tb_diff_line_tx;

`ifdef DIFF_LINE_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid = 1'b0;
    logic       sel1 = 1'b0;

    logic ready4, p4, n4, busy4;
    logic ready1, p1, n1, busy1;
    logic cur_ready, cur_p, cur_n, cur_busy;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    diff_line_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid(valid),
        .ready(ready4), .tx_p(p4), .tx_n(n4), .busy(busy4)
    );

    diff_line_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid(valid),
        .ready(ready1), .tx_p(p1), .tx_n(n1), .busy(busy1)
    );

    assign cur_ready = sel1 ? ready1 : ready4;
    assign cur_p     = sel1 ? p1 : p4;
    assign cur_n     = sel1 ? n1 : n4;
    assign cur_busy  = sel1 ? busy1 : busy4;

    // Expected line symbols, one entry per clock of the frame.
    task automatic build_expected(input logic [7:0] b, input int cpb);
        exp_q.delete();
        for (int k = 0; k < cpb; k++) exp_q.push_back(2'b10);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < cpb; k++) exp_q.push_back(b[i] ? 2'b10 : 2'b01);
        if (PAR == 1)
            for (int k = 0; k < cpb; k++) exp_q.push_back((^b) ? 2'b10 : 2'b01);
        for (int k = 0; k < cpb; k++) exp_q.push_back(2'b00);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        valid = 1'b0;
        repeat (60) step();
    endtask

    // Send one byte from IDLE and check every cycle of its frame plus the following IDLE cycle.
    task automatic send_and_check(input logic [7:0] b, input bit hold_valid,
                                  input int pulse_idx, output int busy_len);
        int cpb;
        cpb = sel1 ? 1 : 4;
        build_expected(b, cpb);
        checks++;
        if (cur_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_ready got %b want 1", cur_ready);
        end
        data_in = b;
        valid   = 1'b1;
        step();
        if (!hold_valid) valid = 1'b0;
        data_in  = 8'($urandom);
        busy_len = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == pulse_idx + 1 && !hold_valid) valid = 1'b0;
            checks++;
            if ({cur_p, cur_n} !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL frame_sym byte %h cpb %0d cycle %0d got %b want %b",
                         b, cpb, i, {cur_p, cur_n}, exp_q[i]);
            end
            checks++;
            if (cur_busy !== 1'b1 || cur_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL frame_status cycle %0d got busy %b ready %b want busy 1 ready 0",
                         i, cur_busy, cur_ready);
            end
            if (cur_busy === 1'b1) busy_len++;
            if (i == pulse_idx) begin
                valid   = 1'b1;
                data_in = 8'h3C;
            end
            step();
        end
        if (!hold_valid) valid = 1'b0;
        checks++;
        if (cur_ready !== 1'b1 || cur_busy !== 1'b0 || {cur_p, cur_n} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL post_frame_idle got ready %b busy %b line %b want 1 0 00",
                     cur_ready, cur_busy, {cur_p, cur_n});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        #3;
        checks++;
        if (ready4 !== 1'b0 || busy4 !== 1'b0 || {p4, n4} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_state got ready %b busy %b line %b want 0 0 00",
                     ready4, busy4, {p4, n4});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (ready4 !== 1'b1 || ready1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_release got %b/%b want 1/1", ready4, ready1);
        end
        for (int i = 0; i < 50; i++) begin
            checks++;
            if ({p4, n4} !== 2'b00 || busy4 !== 1'b0 || ready4 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL idle_hold cycle %0d got line %b busy %b ready %b want 00 0 1",
                         i, {p4, n4}, busy4, ready4);
            end
            step();
        end
    endtask

    task automatic test_single_a5();
        int len;
        sel1 = 1'b0;
        settle();
        send_and_check(8'hA5, 1'b0, -1, len);
        checks++;
        if (len !== 4 * (10 + PAR)) begin
            errors++;
            $display("[TB] FAIL a5_busy_len got %0d want %0d", len, 4 * (10 + PAR));
        end
    endtask

    task automatic test_parity();
        int len;
        sel1 = 1'b0;
        settle();
        send_and_check(8'h07, 1'b0, -1, len);
        checks++;
        if (len !== 4 * (10 + PAR)) begin
            errors++;
            $display("[TB] FAIL parity_frame_len got %0d want %0d", len, 4 * (10 + PAR));
        end
    endtask

    task automatic test_back_to_back();
        int len;
        sel1 = 1'b1;
        settle();
        send_and_check(8'h00, 1'b1, -1, len);
        send_and_check(8'hFF, 1'b1, -1, len);
        valid = 1'b0;
        settle();
    endtask

    task automatic test_mid_reset();
        sel1 = 1'b0;
        settle();
        data_in = 8'h5A;
        valid   = 1'b1;
        step();
        valid   = 1'b0;
        repeat (17) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({p4, n4} !== 2'b00 || busy4 !== 1'b0 || ready4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got line %b busy %b ready %b want 00 0 0",
                     {p4, n4}, busy4, ready4);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (ready4 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_abort got %b want 1", ready4);
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({p4, n4} !== 2'b00 || busy4 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL residual_bits cycle %0d got line %b busy %b want 00 0",
                         i, {p4, n4}, busy4);
            end
            step();
        end
    endtask

    task automatic test_ignored_request();
        int len;
        sel1 = 1'b0;
        settle();
        send_and_check(8'h81, 1'b0, 5, len);
        settle();
        send_and_check(8'h81, 1'b0, 4 * (10 + PAR) - 1, len);
        step();
        checks++;
        if (busy4 !== 1'b0 || {p4, n4} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL late_request_ignored got busy %b line %b want 0 00",
                     busy4, {p4, n4});
        end
    endtask

    task automatic test_random_frames();
        int len;
        int pulse;
        logic [7:0] b;
        for (int n = 0; n < 8; n++) begin
            sel1 = 1'($urandom_range(0, 1));
            settle();
            b     = 8'($urandom);
            pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1;
            send_and_check(b, 1'b0, pulse, len);
            checks++;
            if (len !== (sel1 ? 1 : 4) * (10 + PAR)) begin
                errors++;
                $display("[TB] FAIL random_frame_len byte %h got %0d want %0d",
                         b, len, (sel1 ? 1 : 4) * (10 + PAR));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_parity();
        test_back_to_back();
        test_mid_reset();
        test_ignored_request();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog_timeout got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
